// File: rtl/rtc_count_gen.sv
// RTC timebase and alarm source: prescaler, seconds Count, MatchData register and
// a RawInt synchroniser with rising-edge pulse.
// Optional feature macro: RTC_ALIGNED_LOAD_EN
//   defined   - a load while running is held until the next second boundary (LOAD state).
//   undefined - a load takes effect on the next cycle and restarts the prescaler.
module rtc_count_gen #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  TickEn,
    input  logic [PRESCALE_W-1:0] PrescaleVal,
    input  logic                  CtrlEn,
    input  logic                  LoadWr,
    input  logic [31:0]           LoadData,
    input  logic                  MatchWr,
    input  logic [31:0]           MatchWrData,
    input  logic                  RawInt,
    output logic [31:0]           Count,
    output logic [31:0]           MatchData,
    output logic                  SecTick,
    output logic                  RawIntEdge,
    output logic                  LoadPending
);

`ifdef RTC_ALIGNED_LOAD_EN
    typedef enum logic [1:0] {StStopped, StRunning, StLoad} state_e;
`else
    typedef enum logic [1:0] {StStopped, StRunning} state_e;
`endif

    state_e                  state_q, state_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [31:0]             count_q, count_d;
    logic [31:0]             match_q, match_d;
    logic                    sec_tick_q, sec_tick_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    prev_q;
    logic                    terminal;

`ifdef RTC_ALIGNED_LOAD_EN
    logic [31:0]             hold_q, hold_d;
    logic                    pend_q, pend_d;
`endif

    assign terminal = TickEn && (presc_q == PrescaleVal);

    // Next-state logic for the run/load FSM, prescaler, count and match register.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        count_d    = count_q;
        sec_tick_d = 1'b0;
        match_d    = MatchWr ? MatchWrData : match_q;
`ifdef RTC_ALIGNED_LOAD_EN
        hold_d     = hold_q;
        pend_d     = pend_q;
`endif
        unique case (state_q)
            StStopped: begin
                presc_d = '0;
                if (LoadWr) count_d = LoadData;
                if (CtrlEn) state_d = StRunning;
            end
`ifdef RTC_ALIGNED_LOAD_EN
            StRunning: begin
                if (!CtrlEn) begin
                    state_d = StStopped;
                    presc_d = '0;
                end else begin
                    if (terminal) begin
                        presc_d    = '0;
                        count_d    = count_q + 32'd1;
                        sec_tick_d = 1'b1;
                    end else if (TickEn) begin
                        presc_d = presc_q + PRESCALE_W'(1);
                    end
                    // A load coincident with a boundary waits for the following one.
                    if (LoadWr) begin
                        hold_d  = LoadData;
                        pend_d  = 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (!CtrlEn) begin
                    state_d = StStopped;
                    presc_d = '0;
                    count_d = hold_q;
                    pend_d  = 1'b0;
                end else if (terminal) begin
                    state_d    = StRunning;
                    presc_d    = '0;
                    count_d    = LoadWr ? LoadData : hold_q;
                    sec_tick_d = 1'b1;
                    pend_d     = 1'b0;
                end else begin
                    if (TickEn) presc_d = presc_q + PRESCALE_W'(1);
                    if (LoadWr) hold_d = LoadData;
                end
            end
`else
            StRunning: begin
                if (!CtrlEn) state_d = StStopped;
                if (LoadWr) begin
                    // Immediate load restarts the second; any coincident tick is dropped.
                    count_d = LoadData;
                    presc_d = '0;
                end else if (!CtrlEn) begin
                    presc_d = '0;
                end else if (terminal) begin
                    presc_d    = '0;
                    count_d    = count_q + 32'd1;
                    sec_tick_d = 1'b1;
                end else if (TickEn) begin
                    presc_d = presc_q + PRESCALE_W'(1);
                end
            end
`endif
            default: begin
                state_d = StStopped;
                presc_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= StStopped;
            presc_q    <= '0;
            count_q    <= '0;
            match_q    <= '0;
            sec_tick_q <= 1'b0;
`ifdef RTC_ALIGNED_LOAD_EN
            hold_q     <= '0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            match_q    <= match_d;
            sec_tick_q <= sec_tick_d;
`ifdef RTC_ALIGNED_LOAD_EN
            hold_q     <= hold_d;
            pend_q     <= pend_d;
`endif
        end
    end

    // RawInt synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RawInt};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign Count      = count_q;
    assign MatchData  = match_q;
    assign SecTick    = sec_tick_q;
    assign RawIntEdge = sync_q[SYNC_STAGES-1] & ~prev_q;
`ifdef RTC_ALIGNED_LOAD_EN
    assign LoadPending = pend_q;
`else
    assign LoadPending = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_count_gen.sv
// Self-checking bench for rtc_count_gen: directed scenarios followed by randomized
// stimulus, every cycle compared against a behavioural model of the RTC.
module tb_rtc_count_gen;

    localparam int unsigned PW = 16;
    localparam int unsigned NS = 2;
`ifdef RTC_ALIGNED_LOAD_EN
    localparam bit Aligned = 1'b1;
`else
    localparam bit Aligned = 1'b0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          TickEn = 1'b0;
    logic [PW-1:0] PrescaleVal = '0;
    logic          CtrlEn = 1'b0;
    logic          LoadWr = 1'b0;
    logic [31:0]   LoadData = '0;
    logic          MatchWr = 1'b0;
    logic [31:0]   MatchWrData = '0;
    logic          RawInt = 1'b0;
    logic [31:0]   Count, MatchData;
    logic          SecTick, RawIntEdge, LoadPending;

    rtc_count_gen #(.PRESCALE_W(PW), .SYNC_STAGES(NS)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .TickEn      (TickEn),
        .PrescaleVal (PrescaleVal),
        .CtrlEn      (CtrlEn),
        .LoadWr      (LoadWr),
        .LoadData    (LoadData),
        .MatchWr     (MatchWr),
        .MatchWrData (MatchWrData),
        .RawInt      (RawInt),
        .Count       (Count),
        .MatchData   (MatchData),
        .SecTick     (SecTick),
        .RawIntEdge  (RawIntEdge),
        .LoadPending (LoadPending)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: running flag, pending-load flag, ticks into the current second.
    bit          m_run, m_pend, m_sec;
    int unsigned m_ticks;
    logic [31:0] m_count, m_match, m_hold;
    bit          m_hist [0:NS];   // m_hist[0] = RawInt seen at the latest edge

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit last_tick;
        if (PRESET) begin
            m_run = 0; m_pend = 0; m_sec = 0; m_ticks = 0;
            m_count = '0; m_match = '0; m_hold = '0;
            for (int i = 0; i <= NS; i++) m_hist[i] = 0;
            return;
        end
        for (int i = NS; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = RawInt;
        if (MatchWr) m_match = MatchWrData;
        m_sec = 0;
        last_tick = m_run && TickEn && (m_ticks == int'(PrescaleVal));
        if (!m_run) begin
            m_ticks = 0;
            if (LoadWr) m_count = LoadData;
            if (CtrlEn) m_run = 1;
        end else if (Aligned) begin
            if (!CtrlEn) begin
                m_run = 0; m_ticks = 0;
                if (m_pend) m_count = m_hold;
                m_pend = 0;
            end else if (last_tick) begin
                m_ticks = 0; m_sec = 1;
                if (m_pend) begin
                    m_count = LoadWr ? LoadData : m_hold;
                    m_pend = 0;
                end else begin
                    m_count = m_count + 32'd1;
                    if (LoadWr) begin m_hold = LoadData; m_pend = 1; end
                end
            end else begin
                if (TickEn) m_ticks++;
                if (LoadWr) begin m_hold = LoadData; m_pend = 1; end
            end
        end else begin
            if (!CtrlEn) m_run = 0;
            if (LoadWr) begin
                m_count = LoadData; m_ticks = 0;
            end else if (!CtrlEn) begin
                m_ticks = 0;
            end else if (last_tick) begin
                m_ticks = 0; m_sec = 1; m_count = m_count + 32'd1;
            end else if (TickEn) begin
                m_ticks++;
            end
        end
    endtask

    // One clock: model follows the inputs sampled at the edge, then outputs are compared.
    task automatic step();
        @(posedge PCLK);
        #1;
        model_update();
        check_eq("Count", Count, m_count);
        check_eq("MatchData", MatchData, m_match);
        check_eq("SecTick", {31'b0, SecTick}, {31'b0, m_sec});
        check_eq("LoadPending", {31'b0, LoadPending}, {31'b0, m_pend});
        check_eq("RawIntEdge", {31'b0, RawIntEdge}, {31'b0, m_hist[NS-1] & ~m_hist[NS]});
    endtask

    int first_edge, n_edges;

    initial begin
        // Reset state
        PRESET = 1'b1;
        step(); step();
        check_eq("rst_count", Count, 32'h0);
        check_eq("rst_pend", {31'b0, LoadPending}, 32'h0);

        // 1: PrescaleVal=3, count advances every 4 ticks
        PRESET = 1'b0; CtrlEn = 1'b1; TickEn = 1'b1; PrescaleVal = 16'd3;
        for (int i = 0; i < 9; i++) step();
        check_eq("t1_count", Count, 32'd2);
        check_eq("t1_sectick", {31'b0, SecTick}, 32'd1);

        // 2: load all-ones while stopped, then wrap on the first second
        CtrlEn = 1'b0;
        step();
        LoadWr = 1'b1; LoadData = 32'hFFFF_FFFF;
        step();
        check_eq("t2_load", Count, 32'hFFFF_FFFF);
        LoadWr = 1'b0; CtrlEn = 1'b1; PrescaleVal = 16'd0;
        step();
        step();
        check_eq("t2_wrap", Count, 32'h0);

        // 3: load mid-second while running
        PrescaleVal = 16'd7;
        step(); step(); step();
        LoadWr = 1'b1; LoadData = 32'h1000;
        step();
        LoadWr = 1'b0;
        check_eq("t3_pend", {31'b0, LoadPending}, {31'b0, Aligned});
        check_eq("t3_count", Count, Aligned ? 32'h0 : 32'h1000);
        step(); step(); step(); step();
        check_eq("t3_applied", Count, 32'h1000);
        check_eq("t3_pend_clr", {31'b0, LoadPending}, 32'h0);

        // 4: RawInt rising and stuck high gives a single pulse after the 2nd edge
        RawInt = 1'b1;
        first_edge = -1; n_edges = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (RawIntEdge) begin
                n_edges++;
                if (first_edge < 0) first_edge = i;
            end
        end
        check_eq("t4_pulses", n_edges, 32'd1);
        check_eq("t4_when", first_edge, NS);

        // 5: reset while a load is pending discards it
        PRESET = 1'b1;
        step();
        PRESET = 1'b0; CtrlEn = 1'b1; TickEn = 1'b1; PrescaleVal = 16'd7;
        step(); step(); step();
        LoadWr = 1'b1; LoadData = 32'hABCD;
        step();
        LoadWr = 1'b0; PRESET = 1'b1;
        step();
        check_eq("t5_count", Count, 32'h0);
        check_eq("t5_pend", {31'b0, LoadPending}, 32'h0);
        PRESET = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // 6: stopping with a load pending applies it at once
        TickEn = 1'b0; LoadWr = 1'b1; LoadData = 32'h55;
        step();
        LoadWr = 1'b0; CtrlEn = 1'b0;
        step();
        check_eq("t6_count", Count, 32'h55);
        check_eq("t6_pend", {31'b0, LoadPending}, 32'h0);
        TickEn = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_eq("t6_hold", Count, 32'h55);

        // Randomized phase
        PRESET = 1'b1;
        step();
        for (int i = 0; i < 4000; i++) begin
            PRESET = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) CtrlEn = ~CtrlEn;
            if (!m_run && $urandom_range(0, 3) == 0) PrescaleVal = PW'($urandom_range(0, 5));
            TickEn = ($urandom_range(0, 9) < 7);
            LoadWr = ($urandom_range(0, 7) == 0);
            if (Aligned && m_run && !CtrlEn) LoadWr = 1'b0;
            LoadData = ($urandom_range(0, 1) == 0) ? $urandom()
                                                   : 32'hFFFF_FFFF - $urandom_range(0, 3);
            MatchWr = ($urandom_range(0, 9) == 0);
            MatchWrData = $urandom();
            if ($urandom_range(0, 5) == 0) RawInt = ~RawInt;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
